if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register. It owns the PC and issues requests over a req/ready handshake to instruction memory, which may take several cycles to respond. It latches fetched instruction words and PC+4 for decode, and honours stall from the hazard unit and redirect from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on a bubble (sll $0,$0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC and IF/ID (load-use hazard)
redirect  in  1  branch/jump taken; overrides stall
redirect_pc  in  32  target PC, valid when redirect=1
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  request accepted and data returned this cycle
pc  out  32  PC of the next instruction to be requested
id_instr  out  32  IF/ID instruction
id_pc_plus4  out  32  IF/ID PC+4
id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at posedge): pc=fetch_addr=RESET_PC, state=S_FETCH, skid empty, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0. imem_req is forced to 0 while rst=1.
- imem_addr=fetch_addr (registered). Once a request is raised, req and addr stay constant until imem_ready=1.
- States:
  - S_FETCH: req=1.
  - S_HOLD: req=0. Skid holds a fetched word blocked by stall.
  - S_DROP: req=1 with the stale addr. The response will be discarded.
- S_FETCH, imem_ready=1, stall=0: IF/ID<={imem_rdata, fetch_addr+4, 1}. pc and fetch_addr<=pc+4. Remain in S_FETCH. Back-to-back fetches at 1/cycle with a zero-wait memory.
- S_FETCH, imem_ready=1, stall=1: skid<={imem_rdata, fetch_addr+4}. IF/ID holds. Go to S_HOLD.
- S_FETCH, imem_ready=0: if stall=0, IF/ID<=bubble (valid=0, instr=NOP_INSTR); if stall=1, IF/ID holds.
- S_HOLD, stall=1: everything holds.
- S_HOLD, stall=0: IF/ID<=skid with valid=1. pc and fetch_addr<=pc+4. Go to S_FETCH.
- S_DROP, imem_ready=1: discard rdata, fetch_addr<=pc, go to S_FETCH. IF/ID is bubble unless stall=1.
- S_DROP, imem_ready=0: stay in S_DROP.
- redirect=1 (highest priority below rst, any state): pc<=redirect_pc. IF/ID<=bubble even if stall=1. Skid cleared. Next state:
  - from S_FETCH with imem_ready=0: go to S_DROP.
  - from S_FETCH with imem_ready=1: data discarded, fetch_addr<=redirect_pc, go to S_FETCH.
  - from S_HOLD: fetch_addr<=redirect_pc, go to S_FETCH.
  - from S_DROP: stay in S_DROP; pc updated only.
- Repeated redirect: the last target wins.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. redirect_pc[1:0] is ignored and forced to 00.

Optional Feature:
IF_PERF_CNT_EN — when defined, adds outputs fetch_cnt[31:0] and bubble_cnt[31:0].
- Both are cleared by rst and wrap at 2^32.
- fetch_cnt increments on every IF/ID load with valid=1.
- bubble_cnt increments on every cycle IF/ID is loaded with a bubble.
- Not defined: ports absent, no counter logic.

Test Plan:
1. Reset then zero-wait memory returning addr-based words: id_instr follows rdata(0),(4),(8) on consecutive cycles, with id_pc_plus4 = 4,8,12 and id_valid=1 from the 2nd cycle after reset release.
2. Memory with 2-cycle latency: imem_addr stays 0x0 for 3 cycles, id_valid pattern is 0,0,1 per fetch, and pc advances by 4 only on ready.
3. stall=1 asserted with ready in the same cycle at addr 0x8: IF/ID holds the 0x4 word, req=0 while stalled, and after release id_instr=rdata(0x8) with id_pc_plus4=0xC.
4. redirect to 0x100 while the 0x10 request is pending (ready 2 cycles later): req stays on 0x10 until ready, the 0x10 data never appears with valid=1, and the next valid instruction has id_pc_plus4=0x104.
5. redirect and stall together in S_HOLD: IF/ID becomes bubble (id_valid=0), the skid word is lost, and the next fetch addr is redirect_pc.
6. rst asserted mid-S_DROP: next cycle state is S_FETCH with imem_addr=RESET_PC and id_valid=0; with IF_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : Instruction-fetch stage plus the IF/ID pipeline register.
//                Owns the PC and fetches over a req/ready handshake to an
//                instruction memory of arbitrary latency. It holds a fetched
//                word in a one-entry skid while decode is stalled, and it
//                squashes in-flight fetches on a branch/jump redirect.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC     PC loaded on reset
//    NOP_INSTR    instruction word placed in IF/ID for a bubble
//  Ports
//    clk          clock; all state updates on the rising edge
//    rst          synchronous active-high reset
//    stall        hold PC and IF/ID (load-use hazard)
//    redirect     branch/jump taken; overrides stall
//    redirect_pc  redirect target (bits [1:0] ignored)
//    imem_req     fetch request (forced low while rst=1)
//    imem_addr    fetch address, stable while imem_req=1 and imem_ready=0
//    imem_rdata   fetched word, valid when imem_ready=1
//    imem_ready   request accepted and data returned this cycle
//    pc           PC of the next instruction to be requested
//    id_instr     IF/ID instruction word
//    id_pc_plus4  IF/ID PC+4
//    id_valid     IF/ID holds a real instruction
//  Optional feature (macro IF_PERF_CNT_EN)
//    fetch_cnt    count of IF/ID loads carrying a valid instruction
//    bubble_cnt   count of cycles IF/ID is loaded with a bubble
// ============================================================================
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [31:0] c_pc_step   = 32'd4;
  localparam logic [31:0] c_align_msk = 32'hFFFF_FFFC;

  // S_FETCH : request outstanding on r_fetch_addr
  // S_HOLD  : no request; skid holds a word fetched while decode stalled
  // S_DROP  : request on a stale address still outstanding; its data is junk
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
  logic [31:0] r_id_instr, w_id_instr_nxt;
  logic [31:0] r_id_pc4, w_id_pc4_nxt;
  logic        r_id_valid, w_id_valid_nxt;
  logic        w_load_valid;
  logic        w_load_bubble;
  logic [31:0] w_redirect_tgt;

  assign w_redirect_tgt = redirect_pc & c_align_msk;

  // Request is a pure function of state so it cannot drop mid-handshake.
  assign imem_req    = !rst && (r_state != S_HOLD);
  assign imem_addr   = r_fetch_addr;
  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc4;
  assign id_valid    = r_id_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc4_nxt     = r_id_pc4;
    w_id_valid_nxt   = r_id_valid;
    w_load_valid     = 1'b0;
    w_load_bubble    = 1'b0;

    if (redirect) begin
      w_pc_nxt         = w_redirect_tgt;
      w_skid_instr_nxt = NOP_INSTR;
      w_skid_pc4_nxt   = 32'd0;
      w_load_bubble    = 1'b1;
      unique case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            w_fetch_addr_nxt = w_redirect_tgt;
            w_state_nxt      = S_FETCH;
          end else begin
            // Address must stay put until the memory answers.
            w_state_nxt = S_DROP;
          end
        end
        S_HOLD: begin
          w_fetch_addr_nxt = w_redirect_tgt;
          w_state_nxt      = S_FETCH;
        end
        default: w_state_nxt = S_DROP;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              w_id_instr_nxt   = imem_rdata;
              w_id_pc4_nxt     = r_fetch_addr + c_pc_step;
              w_load_valid     = 1'b1;
              w_pc_nxt         = r_pc + c_pc_step;
              w_fetch_addr_nxt = r_pc + c_pc_step;
            end else begin
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc4_nxt   = r_fetch_addr + c_pc_step;
              w_state_nxt      = S_HOLD;
            end
          end else if (!stall) begin
            w_load_bubble = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_id_instr_nxt   = r_skid_instr;
            w_id_pc4_nxt     = r_skid_pc4;
            w_load_valid     = 1'b1;
            w_pc_nxt         = r_pc + c_pc_step;
            w_fetch_addr_nxt = r_pc + c_pc_step;
            w_state_nxt      = S_FETCH;
          end
        end
        default: begin
          if (imem_ready) begin
            // Stale response retired; restart on the latest target.
            w_fetch_addr_nxt = r_pc;
            w_state_nxt      = S_FETCH;
          end
          if (!stall) begin
            w_load_bubble = 1'b1;
          end
        end
      endcase
    end

    // A bubble keeps the old PC+4; only instr and valid are meaningful.
    if (w_load_valid) begin
      w_id_valid_nxt = 1'b1;
    end else if (w_load_bubble) begin
      w_id_instr_nxt = NOP_INSTR;
      w_id_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'd0;
      r_id_instr   <= NOP_INSTR;
      r_id_pc4     <= 32'd0;
      r_id_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc4     <= w_id_pc4_nxt;
      r_id_valid   <= w_id_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_load_valid) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_load_bubble) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage. A directed cycle table
//                covers reset, zero-wait and multi-cycle fetch, stall/skid,
//                redirect squashing, reset during a drop and PC wrap. A
//                randomized phase checks the decoded instruction stream
//                against an address-sequence scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks;
  int failures;

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the address; junk when not ready.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic d, input logic [31:0] rp,
                     input logic rdy, input logic q, input logic [31:0] a,
                     input logic [31:0] p, input logic v, input logic [31:0] p4);
    vec_t e;
    e.rst = r; e.stall = s; e.redir = d; e.rpc = rp; e.ready = rdy;
    e.req = q; e.addr = a; e.pc = p; e.valid = v; e.pc4 = p4;
    tbl.push_back(e);
  endtask

  // Randomized-phase state
  logic [31:0] exp_addr;
  int          wait_cnt;
  int          lat;
  int          retired;
  int          idle;
  logic        prev_req;
  logic [31:0] prev_addr;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc4;
  logic        prev_valid;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b0;

    //   rst stl red rpc           rdy | req addr          pc            vld pc4
    add(1, 0, 0, 32'h0,          0,  0, 32'h0,        32'h0,        0, 32'h0);   // reset
    add(0, 0, 0, 32'h0,          1,  1, 32'h4,        32'h4,        1, 32'h4);   // zero-wait
    add(0, 0, 0, 32'h0,          1,  1, 32'h8,        32'h8,        1, 32'h8);
    add(0, 1, 0, 32'h0,          1,  0, 32'h8,        32'h8,        1, 32'h8);   // stall+ready -> skid
    add(0, 1, 0, 32'h0,          0,  0, 32'h8,        32'h8,        1, 32'h8);
    add(0, 0, 0, 32'h0,          0,  1, 32'hC,        32'hC,        1, 32'hC);   // release skid
    add(0, 0, 0, 32'h0,          0,  1, 32'hC,        32'hC,        0, 32'h0);   // 2-cycle latency
    add(0, 0, 0, 32'h0,          0,  1, 32'hC,        32'hC,        0, 32'h0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h10,       32'h10,       1, 32'h10);
    add(0, 0, 1, 32'h100,        0,  1, 32'h10,       32'h100,      0, 32'h0);   // redirect, pending
    add(0, 0, 0, 32'h0,          0,  1, 32'h10,       32'h100,      0, 32'h0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h100,      32'h100,      0, 32'h0);   // stale data dropped
    add(0, 0, 0, 32'h0,          1,  1, 32'h104,      32'h104,      1, 32'h104);
    add(0, 1, 0, 32'h0,          1,  0, 32'h104,      32'h104,      1, 32'h104); // into hold
    add(0, 1, 1, 32'h203,        0,  1, 32'h200,      32'h200,      0, 32'h0);   // redirect+stall in hold
    add(0, 0, 0, 32'h0,          1,  1, 32'h204,      32'h204,      1, 32'h204);
    add(0, 0, 1, 32'h300,        0,  1, 32'h204,      32'h300,      0, 32'h0);   // into drop
    add(1, 0, 0, 32'h0,          0,  0, 32'h0,        32'h0,        0, 32'h0);   // reset mid-drop
    add(0, 0, 0, 32'h0,          0,  1, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 1, 32'hFFFF_FFFC,  0,  1, 32'h0,        32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 0, 32'h0,          1,  1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h0,        32'h0,        1, 32'h0);   // wrap
    add(0, 1, 0, 32'h0,          0,  1, 32'h0,        32'h0,        1, 32'h0);   // stall, no data
    add(0, 0, 0, 32'h0,          1,  1, 32'h4,        32'h4,        1, 32'h4);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst         = tbl[i].rst;
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      imem_ready  = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d req", i),   {31'd0, imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("row%0d addr", i),  imem_addr, tbl[i].addr);
      chk($sformatf("row%0d pc", i),    pc, tbl[i].pc);
      chk($sformatf("row%0d valid", i), {31'd0, id_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("row%0d instr", i), id_instr,
          tbl[i].valid ? mem_word(tbl[i].pc4 - 32'd4) : 32'h0);
      if (tbl[i].valid || tbl[i].rst) begin
        chk($sformatf("row%0d pc4", i), id_pc_plus4, tbl[i].pc4);
      end
`ifdef IF_PERF_CNT_EN
      if (tbl[i].rst) begin
        chk($sformatf("row%0d fetch_cnt", i),  fetch_cnt, 32'd0);
        chk($sformatf("row%0d bubble_cnt", i), bubble_cnt, 32'd0);
      end
`endif
    end

    // ---------------- randomized phase ----------------
    @(negedge clk);
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_addr = 32'h0;
    wait_cnt = 0;
    lat      = int'($urandom_range(0, 3));
    retired  = 0;
    idle     = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      imem_ready  = imem_req && (wait_cnt >= lat);
      prev_req    = imem_req;
      prev_addr   = imem_addr;
      prev_instr  = id_instr;
      prev_pc4    = id_pc_plus4;
      prev_valid  = id_valid;
      @(posedge clk);
      #1;
      if (imem_ready) begin
        wait_cnt = 0;
        lat      = int'($urandom_range(0, 3));
      end else if (prev_req) begin
        wait_cnt++;
      end

      if (prev_req && !imem_ready) begin
        chk("rnd req_held",  {31'd0, imem_req}, 32'd1);
        chk("rnd addr_held", imem_addr, prev_addr);
      end

      if (redirect) begin
        chk("rnd redirect_bubble", {31'd0, id_valid}, 32'd0);
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
        idle     = 0;
      end else if (stall) begin
        chk("rnd stall_valid", {31'd0, id_valid}, {31'd0, prev_valid});
        chk("rnd stall_instr", id_instr, prev_instr);
        if (prev_valid) chk("rnd stall_pc4", id_pc_plus4, prev_pc4);
      end else if (id_valid) begin
        chk("rnd stream_pc4",   id_pc_plus4, exp_addr + 32'd4);
        chk("rnd stream_instr", id_instr, mem_word(exp_addr));
        exp_addr = exp_addr + 32'd4;
        retired++;
        idle = 0;
      end

      idle++;
      if (idle > 64) begin
        chk("rnd progress_timeout", 32'(idle), 32'd64);
        break;
      end
    end

    checks++;
    if (retired < 200) begin
      failures++;
      $display("FAIL rnd retired actual=%0d required>=200", retired);
    end
`ifdef IF_PERF_CNT_EN
    chk("rnd fetch_cnt", fetch_cnt, 32'(retired));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
